// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light monitor and light generator.
//   RAG_*    : lamp encodings of {red, amber, green}
//   ERR_*    : err_code values reported by the monitor
//   mon_state_e : monitor state encoding
package traffic_pkg;

  localparam logic [2:0] RAG_OFF       = 3'b000;
  localparam logic [2:0] RAG_RED       = 3'b100;
  localparam logic [2:0] RAG_RED_AMBER = 3'b110;
  localparam logic [2:0] RAG_GREEN     = 3'b001;
  localparam logic [2:0] RAG_AMBER     = 3'b010;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_ORDER   = 2'b10;
  localparam logic [1:0] ERR_STALL   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_FAULT   = 2'd3
  } mon_state_e;

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Lamp observation and status bundle of the traffic light monitor.
//   enable, red, amber, green : driven by the master (lamp side / controller)
//   locked, err, err_code     : monitor status
//   cycles                    : completed light cycles, CYCLE_W bits
interface traffic_light_monitor_if #(
  parameter int CYCLE_W = 8
);
  logic               enable;
  logic               red;
  logic               amber;
  logic               green;
  logic               locked;
  logic               err;
  logic [1:0]         err_code;
  logic [CYCLE_W-1:0] cycles;

  modport master (
    output enable, red, amber, green,
    input  locked, err, err_code, cycles
  );

  modport slave (
    input  enable, red, amber, green,
    output locked, err, err_code, cycles
  );
endinterface

// File: rtl/rag_successor.sv
// Combinational legal-sequence lookup for the lamp encoding.
//   rag      : current {red, amber, green}
//   rag_next : the only legal successor of rag (000 when rag is illegal)
//   legal    : rag is one of the four legal encodings
module rag_successor
  import traffic_pkg::*;
(
  input  logic [2:0] rag,
  output logic [2:0] rag_next,
  output logic       legal
);

  always_comb begin
    rag_next = RAG_OFF;
    legal    = 1'b0;
    case (rag)
      RAG_RED: begin
        rag_next = RAG_RED_AMBER;
        legal    = 1'b1;
      end
      RAG_RED_AMBER: begin
        rag_next = RAG_GREEN;
        legal    = 1'b1;
      end
      RAG_GREEN: begin
        rag_next = RAG_AMBER;
        legal    = 1'b1;
      end
      RAG_AMBER: begin
        rag_next = RAG_RED;
        legal    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Traffic light sequence monitor. Watches {red, amber, green} every clock,
// locks onto the legal sequence 100->110->001->010->100, counts completed
// cycles and latches the first fault until reset.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   mon : traffic_light_monitor_if.slave (enable, lamps in; status out)
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | monitoring off, waiting for enable
// ST_ACQUIRE | waiting for first legal lamp pattern, illegal ignored
// ST_TRACK   | locked, checking order and hold time every cycle
// ST_FAULT   | error latched, frozen until rst
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int MAX_HOLD = 1,
  parameter int CYCLE_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  traffic_light_monitor_if.slave   mon
);

  // Hold time is a down-counter loaded with MAX_HOLD-1 on entry to a
  // pattern; a repeat of the pattern at terminal count zero is a stall.
  localparam int                 HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_INIT = HOLD_W'(MAX_HOLD - 1);
  localparam logic [CYCLE_W-1:0] CYC_MAX   = '1;

  mon_state_e         state_q, state_d;
  logic [2:0]         prev_q, prev_d;
  logic [2:0]         exp_q, exp_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [CYCLE_W-1:0] cycles_q, cycles_d;
  logic [1:0]         err_code_q, err_code_d;

  logic [2:0] rag;
  logic [2:0] rag_next;
  logic       rag_legal;

  assign rag = {mon.red, mon.amber, mon.green};

  // The successor of each accepted pattern is captured in exp_q, so one
  // lookup serves both legality of the sample and the order check.
  rag_successor u_succ (
    .rag      (rag),
    .rag_next (rag_next),
    .legal    (rag_legal)
  );

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    exp_d      = exp_q;
    hold_d     = hold_q;
    cycles_d   = cycles_q;
    err_code_d = err_code_q;

    case (state_q)
      ST_IDLE: begin
        if (mon.enable) state_d = ST_ACQUIRE;
      end

      ST_ACQUIRE: begin
        if (!mon.enable) begin
          state_d = ST_IDLE;
        end else if (rag_legal) begin
          state_d = ST_TRACK;
          prev_d  = rag;
          exp_d   = rag_next;
          hold_d  = HOLD_INIT;
        end
      end

      // Errors are checked before enable so a fault seen while enable
      // drops still latches.
      ST_TRACK: begin
        if (!rag_legal) begin
          state_d    = ST_FAULT;
          err_code_d = ERR_ILLEGAL;
        end else if (rag == prev_q) begin
          if (hold_q == '0) begin
            state_d    = ST_FAULT;
            err_code_d = ERR_STALL;
          end else if (!mon.enable) begin
            state_d = ST_IDLE;
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end else if (rag == exp_q) begin
          if (!mon.enable) begin
            state_d = ST_IDLE;
          end else begin
            prev_d = rag;
            exp_d  = rag_next;
            hold_d = HOLD_INIT;
            if (prev_q == RAG_AMBER && cycles_q != CYC_MAX) begin
              cycles_d = cycles_q + 1'b1;
            end
          end
        end else begin
          state_d    = ST_FAULT;
          err_code_d = ERR_ORDER;
        end
      end

      ST_FAULT: ;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      prev_q     <= RAG_OFF;
      exp_q      <= RAG_OFF;
      hold_q     <= '0;
      cycles_q   <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      exp_q      <= exp_d;
      hold_q     <= hold_d;
      cycles_q   <= cycles_d;
      err_code_q <= err_code_d;
    end
  end

  assign mon.locked   = (state_q == ST_TRACK);
  assign mon.err      = (err_code_q != ERR_NONE);
  assign mon.err_code = err_code_q;
  assign mon.cycles   = cycles_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor. Three instances share one stimulus:
//   dut_a MAX_HOLD=1 CYCLE_W=8, dut_b MAX_HOLD=3 CYCLE_W=8,
//   dut_c MAX_HOLD=1 CYCLE_W=2.
// A behavioural model per instance pushes expected status into a queue
// as each sample is driven; entries are popped after the clock edge.
module tb_traffic_light_monitor;

  localparam logic [2:0] R  = 3'b100;
  localparam logic [2:0] RA = 3'b110;
  localparam logic [2:0] G  = 3'b001;
  localparam logic [2:0] A  = 3'b010;

  localparam int M_IDLE  = 0;
  localparam int M_ACQ   = 1;
  localparam int M_TRACK = 2;
  localparam int M_FAULT = 3;

  typedef struct {
    int         st;
    logic [2:0] prev;
    int         hold;
    int         cycles;
    logic [1:0] code;
  } mdl_t;

  typedef struct packed {
    logic       locked;
    logic       err;
    logic [1:0] code;
    logic [7:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_chk  = 0;
  int n_fail = 0;
  int n_step = 0;

  mdl_t m_a, m_b, m_c;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  traffic_light_monitor_if #(.CYCLE_W(8)) if_a ();
  traffic_light_monitor_if #(.CYCLE_W(8)) if_b ();
  traffic_light_monitor_if #(.CYCLE_W(2)) if_c ();

  traffic_light_monitor #(.MAX_HOLD(1), .CYCLE_W(8)) dut_a (.clk(clk), .rst(rst), .mon(if_a));
  traffic_light_monitor #(.MAX_HOLD(3), .CYCLE_W(8)) dut_b (.clk(clk), .rst(rst), .mon(if_b));
  traffic_light_monitor #(.MAX_HOLD(1), .CYCLE_W(2)) dut_c (.clk(clk), .rst(rst), .mon(if_c));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic bit is_legal(input logic [2:0] g);
    return (g == R) || (g == RA) || (g == G) || (g == A);
  endfunction

  function automatic logic [2:0] succ(input logic [2:0] g);
    logic [2:0] seq [4];
    seq[0] = R; seq[1] = RA; seq[2] = G; seq[3] = A;
    for (int i = 0; i < 4; i++) begin
      if (seq[i] == g) return seq[(i + 1) % 4];
    end
    return 3'b000;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t s, input bit r, input bit e,
                                    input logic [2:0] g, input int max_hold, input int cyc_max);
    mdl_t n = s;
    if (r) begin
      n.st = M_IDLE; n.prev = 3'b000; n.hold = 0; n.cycles = 0; n.code = 2'b00;
      return n;
    end
    case (s.st)
      M_IDLE:  if (e) n.st = M_ACQ;
      M_ACQ: begin
        if (!e) n.st = M_IDLE;
        else if (is_legal(g)) begin
          n.st = M_TRACK; n.prev = g; n.hold = 1;
        end
      end
      M_TRACK: begin
        if (!is_legal(g)) begin
          n.st = M_FAULT; n.code = 2'b01;
        end else if (g == s.prev) begin
          if (s.hold == max_hold) begin
            n.st = M_FAULT; n.code = 2'b11;
          end else if (!e) n.st = M_IDLE;
          else n.hold = s.hold + 1;
        end else if (g == succ(s.prev)) begin
          if (!e) n.st = M_IDLE;
          else begin
            if (s.prev == A && s.cycles < cyc_max) n.cycles = s.cycles + 1;
            n.prev = g; n.hold = 1;
          end
        end else begin
          n.st = M_FAULT; n.code = 2'b10;
        end
      end
      default: ;
    endcase
    return n;
  endfunction

  function automatic exp_t to_exp(input mdl_t s);
    exp_t x;
    x.locked = (s.st == M_TRACK);
    x.err    = (s.code != 2'b00);
    x.code   = s.code;
    x.cyc    = 8'(s.cycles);
    return x;
  endfunction

  task automatic cmp(input string name, input int q_size, input exp_t x,
                     input logic lk, input logic er, input logic [1:0] cd, input logic [7:0] cy);
    string p;
    p = $sformatf("%s@%0d", name, n_step);
    chk({p, ".sb_depth"}, q_size, 1);
    chk({p, ".locked"}, lk, x.locked);
    chk({p, ".err"}, er, x.err);
    chk({p, ".err_code"}, cd, x.code);
    chk({p, ".cycles"}, cy, x.cyc);
  endtask

  task automatic step(input bit r, input bit e, input logic [2:0] g);
    exp_t x;
    int   sz;
    rst = r;
    if_a.enable = e; {if_a.red, if_a.amber, if_a.green} = g;
    if_b.enable = e; {if_b.red, if_b.amber, if_b.green} = g;
    if_c.enable = e; {if_c.red, if_c.amber, if_c.green} = g;
    m_a = mdl_step(m_a, r, e, g, 1, 255);
    m_b = mdl_step(m_b, r, e, g, 3, 255);
    m_c = mdl_step(m_c, r, e, g, 1, 3);
    q_a.push_back(to_exp(m_a));
    q_b.push_back(to_exp(m_b));
    q_c.push_back(to_exp(m_c));
    @(posedge clk);
    #1;
    n_step++;
    sz = q_a.size(); x = (sz > 0) ? q_a.pop_front() : '0;
    cmp("a", sz, x, if_a.locked, if_a.err, if_a.err_code, if_a.cycles);
    sz = q_b.size(); x = (sz > 0) ? q_b.pop_front() : '0;
    cmp("b", sz, x, if_b.locked, if_b.err, if_b.err_code, if_b.cycles);
    sz = q_c.size(); x = (sz > 0) ? q_c.pop_front() : '0;
    cmp("c", sz, x, if_c.locked, if_c.err, if_c.err_code, {6'b0, if_c.cycles});
  endtask

  task automatic run_loop();
    step(0, 1, R); step(0, 1, RA); step(0, 1, G); step(0, 1, A);
  endtask

  initial begin
    m_a = '{M_IDLE, 3'b000, 0, 0, 2'b00};
    m_b = m_a;
    m_c = m_a;
    if_a.enable = 1'b0; {if_a.red, if_a.amber, if_a.green} = 3'b000;
    if_b.enable = 1'b0; {if_b.red, if_b.amber, if_b.green} = 3'b000;
    if_c.enable = 1'b0; {if_c.red, if_c.amber, if_c.green} = 3'b000;

    // reset, then three full loops closed by a red
    step(1, 0, 3'b000);
    chk("rst_locked", if_a.locked, 0);
    chk("rst_err_code", if_a.err_code, 0);
    chk("rst_cycles", if_a.cycles, 0);
    step(0, 1, 3'b000);
    chk("idle_to_acq_locked", if_a.locked, 0);
    step(0, 1, R);
    chk("first_red_locked", if_a.locked, 1);
    chk("first_red_cycles", if_a.cycles, 0);
    step(0, 1, RA); step(0, 1, G); step(0, 1, A);
    run_loop(); run_loop();
    step(0, 1, R);
    chk("three_loops_cycles", if_a.cycles, 3);
    chk("three_loops_err", if_a.err, 0);

    // two more loops: the 2-bit counter saturates at 3
    step(0, 1, RA); step(0, 1, G); step(0, 1, A); step(0, 1, R);
    step(0, 1, RA); step(0, 1, G); step(0, 1, A); step(0, 1, R);
    chk("five_loops_cycles_a", if_a.cycles, 5);
    chk("five_loops_sat_c", if_c.cycles, 3);
    chk("five_loops_err_c", if_c.err, 0);

    // hold time: MAX_HOLD=1 stalls on a repeat, MAX_HOLD=3 tolerates 3
    step(0, 1, RA); step(0, 1, RA);
    chk("stall_code_a", if_a.err_code, 3);
    chk("hold2_err_b", if_b.err, 0);
    step(0, 1, RA); step(0, 1, G);
    chk("hold3_then_green_b", if_b.err, 0);
    chk("hold3_locked_b", if_b.locked, 1);
    step(0, 1, A); step(0, 1, A); step(0, 1, A); step(0, 1, A);
    chk("hold4_stall_b", if_b.err_code, 3);
    chk("fault_frozen_cycles_a", if_a.cycles, 5);

    // illegal encoding in TRACK, then legal input and enable low in FAULT
    step(1, 1, R);
    chk("rst_over_enable_locked", if_a.locked, 0);
    chk("rst_from_fault_err", if_a.err, 0);
    step(0, 1, 3'b000); step(0, 1, R); step(0, 1, 3'b011);
    chk("illegal_code", if_a.err_code, 1);
    chk("illegal_locked", if_a.locked, 0);
    step(0, 1, R); step(0, 1, RA); step(0, 0, G);
    chk("illegal_sticky", if_a.err_code, 1);

    // wrong order
    step(1, 0, 3'b000); step(0, 1, 3'b000); step(0, 1, R); step(0, 1, G);
    chk("order_code", if_a.err_code, 2);

    // acquire ignores illegal samples; enable drop preserves cycles
    step(1, 0, 3'b000); step(0, 1, 3'b000);
    step(0, 1, 3'b111); step(0, 1, 3'b000);
    chk("acq_ignores_illegal", if_a.err, 0);
    step(0, 1, G);
    chk("acq_lock_green", if_a.locked, 1);
    step(0, 1, A); step(0, 1, R); step(0, 1, RA); step(0, 1, G); step(0, 1, A);
    step(0, 0, R);
    chk("disable_locked", if_a.locked, 0);
    chk("disable_cycles", if_a.cycles, 1);
    chk("disable_err", if_a.err, 0);
    step(0, 0, R); step(0, 1, R); step(0, 1, R);
    chk("reacq_red_no_count", if_a.cycles, 1);
    step(0, 1, RA); step(0, 1, G); step(0, 1, A); step(0, 1, R);
    chk("reacq_counts", if_a.cycles, 2);

    // enable falls together with an error: fault wins
    step(0, 0, 3'b111);
    chk("err_beats_disable", if_a.err_code, 1);
    step(0, 1, RA);

    // reset out of FAULT and resume
    step(1, 0, 3'b000);
    chk("fault_rst_code", if_a.err_code, 0);
    chk("fault_rst_cycles", if_a.cycles, 0);
    step(0, 1, 3'b000);
    run_loop();
    step(0, 1, R);
    chk("resume_cycles", if_a.cycles, 1);
    chk("resume_locked", if_a.locked, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameter MAX_HOLD, default 1: max consecutive sampled cycles one legal state may persist; 1 = must advance every clock.
REQ-002 Parameter CYCLE_W, default 8: width of the completed-cycle counter.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 enable  input  1  monitoring enable.
REQ-006 red  input  1  observed red lamp.
REQ-007 amber  input  1  observed amber lamp.
REQ-008 green  input  1  observed green lamp.
REQ-009 locked  output  1  monitor synchronised to a legal state.
REQ-010 err  output  1  sticky fault flag.
REQ-011 err_code  output  2  00 none, 01 illegal encoding, 10 wrong order, 11 stall.
REQ-012 cycles  output  CYCLE_W  count of completed light cycles, saturating.

Function
REQ-013 The block SHALL treat {red,amber,green} as rag and recognise only the legal encodings 100, 110, 001, 010.
REQ-014 The block SHALL require the legal successor order 100->110->001->010->100.
REQ-015 The block SHALL implement states IDLE, ACQUIRE, TRACK, FAULT.
REQ-016 IDLE: enable=1 -> ACQUIRE next cycle; otherwise stay.
REQ-017 ACQUIRE: first legal rag sample -> TRACK, store it as prev, hold count=1; illegal samples SHALL be ignored with no error.
REQ-018 TRACK: every cycle, checks in priority order: illegal rag -> FAULT, code 01; rag==prev with hold count==MAX_HOLD -> FAULT, code 11; rag==prev otherwise -> hold count+1; rag==successor(prev) -> prev=rag, hold count=1; any other legal rag -> FAULT, code 10.
REQ-019 cycles SHALL increment by 1 on each accepted 010->100 transition in TRACK and saturate at 2^CYCLE_W-1 with no wrap.
REQ-020 Entry to ACQUIRE on a red sample SHALL NOT increment cycles.
REQ-021 locked SHALL be 1 exactly while in TRACK.
REQ-022 err and err_code SHALL be registered and visible one clock after the offending sample edge; err=1 iff err_code!=00.
REQ-023 FAULT SHALL hold err=1, err_code and cycles frozen, locked=0, regardless of enable or inputs, until rst.
REQ-024 enable=0 in ACQUIRE or TRACK SHALL return to IDLE next cycle, clearing locked, preserving cycles; no error raised.
REQ-025 If enable falls in the same cycle a TRACK error is detected, the error SHALL take priority (-> FAULT).

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, locked=0, err=0, err_code=00, cycles=0, prev=000, hold count=0, from any state including FAULT.
REQ-027 rst SHALL override enable and all inputs in the same cycle.

Structure
REQ-028 A shared package traffic_pkg SHALL hold the rag encodings (RAG_RED=100, RAG_RED_AMBER=110, RAG_GREEN=001, RAG_AMBER=010), the err_code constants and the monitor state typedef.
REQ-029 The successor mapping SHALL be one combinational sub-module rag_successor (input rag, outputs next rag and legal flag), reusable by the light generator.

Verification
REQ-030 rst then enable=1, drive 100,110,001,010 repeated 3 loops, one per clock -> locked=1 from 2nd cycle, err=0, cycles=3.
REQ-031 In TRACK drive 100 then 011 -> next cycle err=1, err_code=01, locked=0; further legal inputs leave err_code=01.
REQ-032 In TRACK drive 100 then 001 -> err=1, err_code=10; with MAX_HOLD=1 drive 110,110 -> err_code=11; with MAX_HOLD=3, 110 held 3 cycles then 001 -> no error.
REQ-033 CYCLE_W=2, run 5 full loops -> cycles=3 stays, err=0.
REQ-034 In ACQUIRE drive 111,000 then 001 -> no error, locked=1; then enable=0 -> IDLE, locked=0, cycles unchanged.
REQ-035 In FAULT assert rst for one clock -> all outputs 0, state IDLE; reassert enable and legal sequence -> normal tracking resumes.
